// File: rtl/flop_chain_seq.sv
`timescale 1ns/1ps
// Sequencing controller for an external DEPTH-stage flop chain: arbitrates two requesters onto
// stage 0, drives the common shift enable and tracks per-stage valid/tag bits. Macro FLOP_CHAIN_SEQ_RR_EN.
module flop_chain_seq #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in0_valid,
  input  logic [WIDTH-1:0]             in0_data,
  output logic                         in0_ready,
  input  logic                         in1_valid,
  input  logic [WIDTH-1:0]             in1_data,
  output logic                         in1_ready,
  output logic                         shift_en,
  output logic [WIDTH-1:0]             chain_d,
  input  logic [WIDTH-1:0]             chain_q,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic                         src_tag
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  if (DEPTH < 2 || DEPTH > 16) begin : g_depth_check
    $error("flop_chain_seq: DEPTH must be within 2..16");
  end

  logic [DEPTH-1:0] v_r;
  logic [DEPTH-1:0] t_r;
  logic [DEPTH-1:0] v_next_s;
  logic [DEPTH-1:0] t_next_s;
  logic [OCC_W-1:0] occ_r;
  logic             head_free_s;
  logic             any_req_s;
  logic             shift_en_s;
  logic             acc_s;
  logic             gnt_s;

  function automatic logic [OCC_W-1:0] popcount(input logic [DEPTH-1:0] vec);
    logic [OCC_W-1:0] cnt;
    cnt = {OCC_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      cnt = cnt + OCC_W'(vec[i]);
    end
    return cnt;
  endfunction

`ifdef FLOP_CHAIN_SEQ_RR_EN
  logic ptr_r;

  // Grant selection: ptr breaks ties, a lone requester always wins
  always_comb begin
    if (in0_valid && in1_valid) begin
      gnt_s = ptr_r;
    end else if (in1_valid) begin
      gnt_s = 1'b1;
    end else begin
      gnt_s = 1'b0;
    end
  end

  // Round-robin pointer: prefer the other requester after every accepted item
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= 1'b0;
    end else if (acc_s) begin
      ptr_r <= !gnt_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end
`else
  // Grant selection: fixed priority, in0 over in1
  always_comb begin
    if (in0_valid) begin
      gnt_s = 1'b0;
    end else if (in1_valid) begin
      gnt_s = 1'b1;
    end else begin
      gnt_s = 1'b0;
    end
  end
`endif

  // Shift decision, handshakes and next valid/tag vectors; no shifting while reset is held
  always_comb begin
    head_free_s = !v_r[DEPTH-1] || out_ready;
    any_req_s   = in0_valid || in1_valid;
    shift_en_s  = rst_n && head_free_s && ((|v_r) || any_req_s);
    acc_s       = shift_en_s && any_req_s;
    in0_ready   = acc_s && !gnt_s && in0_valid;
    in1_ready   = acc_s && gnt_s && in1_valid;
    if (acc_s) begin
      chain_d = gnt_s ? in1_data : in0_data;
    end else begin
      chain_d = {WIDTH{1'b0}};
    end
    if (shift_en_s) begin
      v_next_s = {v_r[DEPTH-2:0], acc_s};
      t_next_s = {t_r[DEPTH-2:0], gnt_s && acc_s};
    end else begin
      v_next_s = v_r;
      t_next_s = t_r;
    end
  end

  // Stage tracking state; occupancy registered from the next valid vector so it matches v_r
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_r   <= {DEPTH{1'b0}};
      t_r   <= {DEPTH{1'b0}};
      occ_r <= {OCC_W{1'b0}};
    end else begin
      v_r   <= v_next_s;
      t_r   <= t_next_s;
      occ_r <= popcount(v_next_s);
    end
  end

  assign shift_en  = shift_en_s;
  assign out_valid = v_r[DEPTH-1];
  assign out_data  = chain_q;
  assign src_tag   = t_r[DEPTH-1];
  assign occupancy = occ_r;

endmodule

// File: tb/tb_flop_chain_seq.sv
`timescale 1ns/1ps
// Directed self-checking bench for flop_chain_seq with a behavioural model of the external chain.
module tb_flop_chain_seq;

  localparam int DEPTH = 4;
  localparam int WIDTH = 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in0_valid = 1'b0;
  logic [WIDTH-1:0] in0_data = 1'b0;
  logic             in0_ready;
  logic             in1_valid = 1'b0;
  logic [WIDTH-1:0] in1_data = 1'b0;
  logic             in1_ready;
  logic             shift_en;
  logic [WIDTH-1:0] chain_d;
  logic [WIDTH-1:0] chain_q;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready = 1'b0;
  logic [2:0]       occupancy;
  logic             src_tag;

  logic [WIDTH-1:0] chain_r [DEPTH];

  int n_cmp = 0;
  int n_err = 0;

  flop_chain_seq #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready),
    .shift_en(shift_en), .chain_d(chain_d), .chain_q(chain_q),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .occupancy(occupancy), .src_tag(src_tag)
  );

  always #5 clk = ~clk;

  // External unreset flop chain sharing one enable
  always @(posedge clk) begin
    if (shift_en) begin
      chain_r[0] <= chain_d;
      for (int i = 1; i < DEPTH; i++) chain_r[i] <= chain_r[i-1];
    end
  end
  assign chain_q = chain_r[DEPTH-1];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    in0_valid = 1'b0; in1_valid = 1'b0; in0_data = 1'b0; in1_data = 1'b0; out_ready = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in0_valid = 1'b1; in0_data = 1'b1; out_ready = 1'b1;
    #3;
    n_cmp++; if (shift_en !== 1'b0) begin n_err++; $display("FAIL rst_shift_en: got %b want 0", shift_en); end
    n_cmp++; if (in0_ready !== 1'b0) begin n_err++; $display("FAIL rst_in0_ready: got %b want 0", in0_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL rst_occupancy: got %0d want 0", occupancy); end
    apply_reset();
    #1;
    n_cmp++; if (shift_en !== 1'b0) begin n_err++; $display("FAIL idle_shift_en: got %b want 0", shift_en); end
  endtask

  task automatic test_single();
    logic exp_v;
    apply_reset();
    in0_valid = 1'b1; in0_data = 1'b1; out_ready = 1'b1;
    #1;
    n_cmp++; if (in0_ready !== 1'b1) begin n_err++; $display("FAIL single_in0_ready: got %b want 1", in0_ready); end
    n_cmp++; if (in1_ready !== 1'b0) begin n_err++; $display("FAIL single_in1_ready: got %b want 0", in1_ready); end
    step();
    in0_valid = 1'b0; in0_data = 1'b0;
    #1;
    n_cmp++; if (occupancy !== 3'd1) begin n_err++; $display("FAIL single_occ: got %0d want 1", occupancy); end
    for (int e = 2; e <= 4; e++) begin
      step();
      exp_v = (e == 4);
      n_cmp++; if (out_valid !== exp_v) begin n_err++; $display("FAIL single_out_valid_e%0d: got %b want %b", e, out_valid, exp_v); end
    end
    n_cmp++; if (out_data !== 1'b1) begin n_err++; $display("FAIL single_out_data: got %b want 1", out_data); end
    n_cmp++; if (src_tag !== 1'b0) begin n_err++; $display("FAIL single_src_tag: got %b want 0", src_tag); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_consumed: got %b want 0", out_valid); end
    n_cmp++; if (shift_en !== 1'b0) begin n_err++; $display("FAIL single_shift_fall: got %b want 0", shift_en); end
    n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL single_occ_end: got %0d want 0", occupancy); end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] bits [4];
    bits[0] = 1'b1; bits[1] = 1'b0; bits[2] = 1'b1; bits[3] = 1'b1;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      in0_valid = 1'b1; in0_data = bits[i];
      #1;
      n_cmp++; if (in0_ready !== 1'b1) begin n_err++; $display("FAIL bp_fill_ready%0d: got %b want 1", i, in0_ready); end
      step();
    end
    in0_data = 1'b0;
    #1;
    n_cmp++; if (occupancy !== 3'd4) begin n_err++; $display("FAIL bp_occ_full: got %0d want 4", occupancy); end
    n_cmp++; if (in0_ready !== 1'b0) begin n_err++; $display("FAIL bp_full_ready: got %b want 0", in0_ready); end
    n_cmp++; if (shift_en !== 1'b0) begin n_err++; $display("FAIL bp_full_shift: got %b want 0", shift_en); end
    step();
    n_cmp++; if (occupancy !== 3'd4) begin n_err++; $display("FAIL bp_hold_occ: got %0d want 4", occupancy); end
    in0_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_drain_valid%0d: got %b want 1", i, out_valid); end
      n_cmp++; if (out_data !== bits[i]) begin n_err++; $display("FAIL bp_drain_data%0d: got %b want %b", i, out_data, bits[i]); end
      step();
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drained: got %b want 0", out_valid); end
    n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL bp_occ_empty: got %0d want 0", occupancy); end
  endtask

  task automatic test_contention();
    logic exp_t;
    apply_reset();
    in0_valid = 1'b1; in0_data = 1'b0; in1_valid = 1'b1; in1_data = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    for (int j = 0; j < 4; j++) begin
`ifdef FLOP_CHAIN_SEQ_RR_EN
      exp_t = (j % 2 == 1);
`else
      exp_t = 1'b0;
`endif
      #1;
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL cont_valid%0d: got %b want 1", j, out_valid); end
      n_cmp++; if (src_tag !== exp_t) begin n_err++; $display("FAIL cont_tag%0d: got %b want %b", j, src_tag, exp_t); end
      n_cmp++; if (out_data !== exp_t) begin n_err++; $display("FAIL cont_data%0d: got %b want %b", j, out_data, exp_t); end
      step();
    end
  endtask

  task automatic test_bubble();
    logic exp_v [4];
    exp_v[0] = 1'b1; exp_v[1] = 1'b0; exp_v[2] = 1'b0; exp_v[3] = 1'b1;
    apply_reset();
    out_ready = 1'b1; in0_valid = 1'b1; in0_data = 1'b1;
    #1;
    step();
    in0_valid = 1'b0; in0_data = 1'b0;
    step();
    step();
    in1_valid = 1'b1; in1_data = 1'b0;
    #1;
    n_cmp++; if (in1_ready !== 1'b1) begin n_err++; $display("FAIL bub_in1_ready: got %b want 1", in1_ready); end
    step();
    in1_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++; if (out_valid !== exp_v[k]) begin n_err++; $display("FAIL bub_valid%0d: got %b want %b", k, out_valid, exp_v[k]); end
      if (k == 0) begin
        n_cmp++; if (out_data !== 1'b1 || src_tag !== 1'b0) begin n_err++; $display("FAIL bub_first: got data %b tag %b want 1 0", out_data, src_tag); end
      end else if (k == 3) begin
        n_cmp++; if (out_data !== 1'b0 || src_tag !== 1'b1) begin n_err++; $display("FAIL bub_second: got data %b tag %b want 0 1", out_data, src_tag); end
      end
      step();
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      in1_valid = 1'b1; in1_data = (i % 2 == 1);
      step();
    end
    out_ready = 1'b1; in1_data = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++; if (in1_ready !== 1'b1) begin n_err++; $display("FAIL sim_ready%0d: got %b want 1", c, in1_ready); end
      n_cmp++; if (src_tag !== 1'b1) begin n_err++; $display("FAIL sim_tag%0d: got %b want 1", c, src_tag); end
      step();
      n_cmp++; if (occupancy !== 3'd4) begin n_err++; $display("FAIL sim_occ%0d: got %0d want 4", c, occupancy); end
    end
  endtask

  task automatic test_reset_mid();
    logic exp_v;
    apply_reset();
    out_ready = 1'b1; in0_valid = 1'b1; in0_data = 1'b1;
    step(); step(); step();
    in0_valid = 1'b0;
    step();
    n_cmp++; if (occupancy !== 3'd3) begin n_err++; $display("FAIL mid_pre_occ: got %0d want 3", occupancy); end
    in0_valid = 1'b1; in1_valid = 1'b1;
    #1;
    rst_n = 1'b0;
    #0.01;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL mid_occ: got %0d want 0", occupancy); end
    n_cmp++; if (in0_ready !== 1'b0 || in1_ready !== 1'b0) begin n_err++; $display("FAIL mid_readies: got %b%b want 00", in0_ready, in1_ready); end
    #0.02;
    rst_n = 1'b1;
    in1_valid = 1'b0;
    step();
    in0_valid = 1'b0;
    n_cmp++; if (occupancy !== 3'd1) begin n_err++; $display("FAIL mid_post_occ: got %0d want 1", occupancy); end
    for (int e = 1; e <= 4; e++) begin
      if (e > 1) step();
      exp_v = (e == 4);
      n_cmp++; if (out_valid !== exp_v) begin n_err++; $display("FAIL mid_post_valid_e%0d: got %b want %b", e, out_valid, exp_v); end
    end
    n_cmp++; if (out_data !== 1'b1) begin n_err++; $display("FAIL mid_post_data: got %b want 1", out_data); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_contention();
    test_bubble();
    test_simultaneous();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/flop_chain_seq.md
# flop_chain_seq

Sequencing controller for a DEPTH-stage positive-edge flop chain, such as the four-stage `F.f[0..3]` chain co-simulated under prsim. It arbitrates two valid/ready requesters onto the chain input and generates the chain's common shift enable. It tracks per-stage valid bits so the chain behaves as an in-order elastic pipeline with a valid/ready output. The chain flops stay outside this block; the controller only drives `chain_d`/`shift_en` and observes `chain_q`.

## Interface
- `DEPTH`, 4: number of chain stages, legal 2..16.
- `WIDTH`, 1: data width per stage.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in0_valid` in 1, `in0_data` in WIDTH, `in0_ready` out 1: requester 0.
- `in1_valid` in 1, `in1_data` in WIDTH, `in1_ready` out 1: requester 1.
- `shift_en` out 1: common enable for all chain stages.
- `chain_d` out WIDTH: data into stage 0.
- `chain_q` in WIDTH: output of stage DEPTH-1.
- `out_valid` out 1, `out_data` out WIDTH, `out_ready` in 1: consumer side.
- `occupancy` out clog2(DEPTH+1): count of valid stages.
- `src_tag` out 1: requester index of the head item.

## Operation
- **State:** valid vector `v[DEPTH-1:0]`, tag vector `t[DEPTH-1:0]`, and arbitration pointer `ptr`.
- **Output side:**
  - `out_valid = v[DEPTH-1]`.
  - `out_data = chain_q`.
  - `src_tag = t[DEPTH-1]`.
- **Shift condition:** `head_free = !v[DEPTH-1] || out_ready`.
  - `shift_en = head_free && (|v[DEPTH-2:0] || v[DEPTH-1] || in0_valid || in1_valid)`.
  - No shift occurs when the chain is empty and idle.
- **Grant:** `gnt` is computed combinationally from the valids and `ptr`.
  - `inN_ready = shift_en && gnt==N && inN_valid`.
  - At most one ready is high in any cycle.
  - `chain_d` = granted data, or all zeros when there is no grant.
- **On a shift edge:**
  - `v <= {v[DEPTH-2:0], acc}`, where `acc` = any input handshake.
  - `t <= {t[DEPTH-2:0], gnt}`.
- **Ordering:** items leave in acceptance order. Bubbles advance with every shift and drain without blocking.
- **Arithmetic:** `occupancy = popcount(v)`, registered, never exceeds DEPTH.
- **Reset values** (all asynchronous to `rst_n` low):
  - `v = 0`, `t = 0`, `ptr = 0`, `occupancy = 0`.
  - Combinational consequences: `out_valid = 0`, `shift_en = 0`, both readies 0.
- **Reset mid-operation:**
  - All valids clear immediately. Chain flop contents are unreset and ignored.
  - The first post-reset shift proceeds normally.

## Timing
- **Latency:** an item accepted at edge k reaches `out_valid` after DEPTH shift edges. With continuous shifting it is visible in the cycle after edge k+DEPTH-1, i.e. DEPTH cycles after acceptance.
- **Throughput:** one item per cycle when `out_ready` is held high.
- **Combinational paths:**
  - `out_ready` → `shift_en`.
  - `out_ready` → `inN_ready`.
  - No path from `inN_valid` to `out_valid`.
- **Simultaneous accept and consume:** `occupancy` is unchanged.
- **Full** (`v` all ones, `out_ready = 0`): `shift_en = 0`, both readies 0, chain holds.
- **Head valid, `out_ready = 0`, lower stages partially empty:** the chain still stalls. There is no per-stage compaction.
- **Handshake rules for requesters:**
  - Must hold `valid` and `data` stable until ready is seen.
  - The controller never drops a granted item.

## Configuration
- `FLOP_CHAIN_SEQ_RR_EN` defined:
  - Round-robin arbitration.
  - `ptr` points to the preferred requester; after a grant to N, `ptr <= !N`.
  - Only one requester valid → it is granted regardless of `ptr`.
- Not defined:
  - Fixed priority, in0 over in1.
  - `ptr` is not implemented.
  - in1 can starve while in0 stays valid.

## Test plan
- **Single item:** DEPTH=4, reset, in0 sends `1` at edge 1 with `out_ready = 1`.
  - `out_valid = 1`, `out_data = 1` and `src_tag = 0` in cycle 5.
  - `shift_en` falls after the consume.
- **Backpressure to full:** stream 1,0,1,1 from in0 with `out_ready = 0`.
  - `occupancy` reaches 4, then `in0_ready = 0` and `shift_en = 0`.
  - Raising `out_ready` drains 1,0,1,1 on consecutive cycles.
- **Contention:** in0 and in1 both continuously valid, `out_ready = 1`.
  - With `FLOP_CHAIN_SEQ_RR_EN`: output tags alternate 0,1,0,1.
  - Without it: tags are all 0.
- **Bubble drain:** accept one item, idle 2 cycles, accept another, `out_ready = 1`.
  - Outputs appear 3 cycles apart, with `out_valid` low between them.
- **Simultaneous accept and consume:** chain full at 4, `out_ready = 1`, in1 valid.
  - `occupancy` stays at 4 across 3 consecutive cycles.
- **Mid-stream reset:** `rst_n` low for 30 ps during a stream with `occupancy = 3`.
  - `out_valid`, `occupancy` and both readies go to 0 immediately.
  - The next accepted item emerges after 4 shift cycles.
